// File: rtl/clock_step_ctrl.sv
// Clock-enable generator: divided ce pulse with run/halt, single-step handshake and stretched core reset.
// Outputs registered; ce_o follows the divider tick by one CLK.
module clock_step_ctrl #(
  parameter int DIV_W    = 20,
  parameter int RST_HOLD = 16,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  input  logic             step_req_i,
  output logic             step_ack_o,
  output logic             ce_o,
  output logic             core_rst_n_o,
  output logic [CNT_W-1:0] tick_cnt_o,
  output logic [1:0]       state_o
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_ce;
  logic               r_rst_n;
  logic               r_ack;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic               w_tick;

  // >= rather than == so a div_i lowered below the running count ticks at once instead of wrapping
  assign w_tick = (r_cnt >= div_i);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_ce       <= 1'b0;
      r_rst_n    <= 1'b0;
      r_ack      <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      if (r_ce)
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);

      if (r_state == S_HOLD || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + DIV_W'(1);

      case (r_state)
        S_HOLD: begin
          r_ce <= 1'b0;
          if (r_hold == HOLD_W'(RST_HOLD)) begin
            r_rst_n <= 1'b1;
            r_state <= run_i ? S_RUN : S_HALT;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (!step_req_i)
            r_ack <= 1'b0;
          // a halt request suppresses a coincident tick
          if (!run_i) begin
            r_state <= S_HALT;
            r_ce    <= 1'b0;
          end else begin
            r_ce <= w_tick;
          end
        end
        S_HALT: begin
          r_ce <= 1'b0;
          if (!step_req_i)
            r_ack <= 1'b0;
          if (run_i)
            r_state <= S_RUN;
          else if (step_req_i && !r_ack)
            r_state <= S_STEP;
        end
        S_STEP: begin
          if (w_tick) begin
            r_ce    <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_ce <= 1'b0;
          end
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

  assign ce_o         = r_ce;
  assign step_ack_o   = r_ack;
  assign core_rst_n_o = r_rst_n;
  assign tick_cnt_o   = r_tick_cnt;
  assign state_o      = r_state;

endmodule
